// File: rtl/mdu_pkg.sv
// Shared MDU definitions: SPECIAL funct codes, decoded MDU op encodings, FSM states.
package mdu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI     = 6'h10;
    localparam logic [5:0] FN_MTHI     = 6'h11;
    localparam logic [5:0] FN_MFLO     = 6'h12;
    localparam logic [5:0] FN_MTLO     = 6'h13;
    localparam logic [5:0] FN_MULT     = 6'h18;
    localparam logic [5:0] FN_MULTU    = 6'h19;
    localparam logic [5:0] FN_DIV      = 6'h1A;
    localparam logic [5:0] FN_DIVU     = 6'h1B;

    typedef enum logic [3:0] {
        NONE_MDU  = 4'd0,
        MULT_MDU  = 4'd1,
        MULTU_MDU = 4'd2,
        DIV_MDU   = 4'd3,
        DIVU_MDU  = 4'd4,
        MFHI_MDU  = 4'd5,
        MFLO_MDU  = 4'd6,
        MTHI_MDU  = 4'd7,
        MTLO_MDU  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Multi-cycle ops that occupy the unit.
    function automatic logic is_md_arith(input mdu_op_e op);
        return (op == MULT_MDU) || (op == MULTU_MDU) || (op == DIV_MDU) || (op == DIVU_MDU);
    endfunction

    function automatic logic is_md_div(input mdu_op_e op);
        return (op == DIV_MDU) || (op == DIVU_MDU);
    endfunction

endpackage

// File: rtl/mdu_decode.sv
// Decodes the E-stage instruction into an MDU operation.
module mdu_decode
    import mdu_pkg::*;
(
    input  logic [XLEN-1:0] instr_i,
    output mdu_op_e         mdu_op_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr_i[31:26];
    assign funct         = instr_i[5:0];
    assign unused_fields = ^instr_i[25:6];

    always_comb begin
        mdu_op_o = NONE_MDU;
        if (opcode == OPC_SPECIAL) begin
            case (funct)
                FN_MULT:  mdu_op_o = MULT_MDU;
                FN_MULTU: mdu_op_o = MULTU_MDU;
                FN_DIV:   mdu_op_o = DIV_MDU;
                FN_DIVU:  mdu_op_o = DIVU_MDU;
                FN_MFHI:  mdu_op_o = MFHI_MDU;
                FN_MFLO:  mdu_op_o = MFLO_MDU;
                FN_MTHI:  mdu_op_o = MTHI_MDU;
                FN_MTLO:  mdu_op_o = MTLO_MDU;
                default:  mdu_op_o = NONE_MDU;
            endcase
        end
    end

endmodule

// File: rtl/mdu.sv
// Fixed-latency multiply/divide unit owning HI/LO; results land on the edge
// ending the last busy cycle, computed from operands latched at start.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [XLEN-1:0] instr,
    input  logic            en,
    output logic            start,
    output logic            busy,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO,
    output logic [XLEN-1:0] rdata
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_op_e         dec_op;
    mdu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    mdu_op_e         op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;

    logic [2*XLEN-1:0] prod_s, prod_u;
    logic [XLEN-1:0]   abs_a, abs_b, div_s, div_u;
    logic [XLEN-1:0]   q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;
    logic              b_zero;

    mdu_decode u_decode (
        .instr_i  (instr),
        .mdu_op_o (dec_op)
    );

    // Result datapath; divisor forced to 1 when zero so no X propagates.
    always_comb begin
        prod_s = {{XLEN{a_q[XLEN-1]}}, a_q} * {{XLEN{b_q[XLEN-1]}}, b_q};
        prod_u = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
        b_zero = (b_q == '0);
        abs_a  = a_q[XLEN-1] ? (~a_q + XLEN'(1)) : a_q;
        abs_b  = b_q[XLEN-1] ? (~b_q + XLEN'(1)) : b_q;
        div_s  = b_zero ? XLEN'(1) : abs_b;
        div_u  = b_zero ? XLEN'(1) : b_q;
        q_mag  = abs_a / div_s;
        r_mag  = abs_a % div_s;
        quo_s  = (a_q[XLEN-1] ^ b_q[XLEN-1]) ? (~q_mag + XLEN'(1)) : q_mag;
        rem_s  = a_q[XLEN-1] ? (~r_mag + XLEN'(1)) : r_mag;
        quo_u  = a_q / div_u;
        rem_u  = a_q % div_u;
    end

    // Next-state, accept and HI/LO write logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    if (is_md_arith(dec_op)) begin
                        start   = 1'b1;
                        a_d     = A;
                        b_d     = B;
                        op_d    = dec_op;
                        cnt_d   = is_md_div(dec_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_d = ST_BUSY;
                    end else if (dec_op == MTHI_MDU) begin
                        hi_d = A;
                    end else if (dec_op == MTLO_MDU) begin
                        lo_d = A;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    case (op_q)
                        MULT_MDU:  {hi_d, lo_d} = prod_s;
                        MULTU_MDU: {hi_d, lo_d} = prod_u;
                        DIV_MDU: begin
                            if (!b_zero) begin
                                lo_d = quo_s;
                                hi_d = rem_s;
                            end
                        end
                        DIVU_MDU: begin
                            if (!b_zero) begin
                                lo_d = quo_u;
                                hi_d = rem_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= NONE_MDU;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (dec_op == MFHI_MDU) begin
            rdata = hi_q;
        end else if (dec_op == MFLO_MDU) begin
            rdata = lo_q;
        end
    end

    assign busy = (state_q == ST_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
